// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter_pkg
// Shared FSM encodings, flag bit indices and datapath width.
// Rev    : 1.0
// ============================================================================
package alu_arbiter_pkg;

    localparam int ALU_W = 16;

    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module : alu
// Combinational ALU: adder-based arithmetic unit and bitwise logic unit.
// Rev    : 1.0
// ============================================================================
module alu
    import alu_arbiter_pkg::*;
(
    input  logic             nau_lu,
    input  logic [2:0]       opcode,
    input  logic [ALU_W-1:0] arg1,
    input  logic [ALU_W-1:0] arg2,
    output logic [ALU_W-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [ALU_W-1:0] x;
    logic [ALU_W-1:0] y;
    logic             cin;
    logic [ALU_W:0]   sum;

    // Every arithmetic op except the right shift is x + y + cin with a chosen x/y/cin.
    always_comb begin
        x   = arg1;
        y   = '0;
        cin = 1'b0;
        case (opcode)
            3'b000: y = arg2;
            3'b001: begin y = ~arg2; cin = 1'b1; end
            3'b010: cin = 1'b1;
            3'b011: y = '1;
            3'b100: begin x = '0; y = ~arg1; cin = 1'b1; end
            3'b110: y = arg1;
            default: ;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {{ALU_W{1'b0}}, cin};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        if (nau_lu) begin
            case (opcode)
                3'b000:  result = arg1 & arg2;
                3'b001:  result = arg1 | arg2;
                3'b010:  result = arg1 ^ arg2;
                3'b011:  result = ~arg1;
                3'b100:  result = ~(arg1 & arg2);
                3'b101:  result = ~(arg1 | arg2);
                3'b110:  result = ~(arg1 ^ arg2);
                default: result = arg2;
            endcase
        end else if (opcode == 3'b111) begin
            result = {1'b0, arg1[ALU_W-1:1]};
            carry  = arg1[0];
        end else begin
            result   = sum[ALU_W-1:0];
            carry    = sum[ALU_W];
            overflow = (x[ALU_W-1] == y[ALU_W-1]) && (sum[ALU_W-1] != x[ALU_W-1]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_arbiter
// Round-robin sharing of one alu between two requesters, valid/ready responses.
// Rev    : 1.0
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [7:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic               rsp_overflow,
    output logic [3:0]         flags,
    output logic               busy
);

    state_t           state_q;
    logic             prio_q;
    logic             gid_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;
    logic             rsp_overflow_q;
    logic [3:0]       flags_q;
    logic [1:0]       rsp_valid_q;
    logic             busy_q;

    logic [1:0]       grant;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;

    // The pointer only matters when both requesters contend.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req_valid[0] && (!req_valid[1] || !prio_q);
        grant[1] = req_valid[1] && (!req_valid[0] ||  prio_q);
        if (state_q != ST_IDLE || !rst_n)
            grant = 2'b00;
    end

    assign req_ready = grant;

    alu alu0 (
        .nau_lu   (op_q[3]),
        .opcode   (op_q[2:0]),
        .arg1     (a_q),
        .arg2     (b_q),
        .result   (alu_result),
        .carry    (alu_carry),
        .overflow (alu_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            prio_q         <= 1'b0;
            gid_q          <= 1'b0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            flags_q        <= '0;
            rsp_valid_q    <= 2'b00;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        gid_q   <= grant[1];
                        prio_q  <= ~grant[1];
                        op_q    <= grant[1] ? req_op[7:4] : req_op[3:0];
                        a_q     <= grant[1] ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                        b_q     <= grant[1] ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q       <= alu_result;
                    rsp_carry_q        <= alu_carry;
                    rsp_overflow_q     <= alu_overflow;
                    flags_q[FLG_C]     <= alu_carry;
                    flags_q[FLG_V]     <= alu_overflow;
                    flags_q[FLG_Z]     <= (alu_result == '0);
                    flags_q[FLG_N]     <= alu_result[WIDTH-1];
                    rsp_valid_q        <= 2'b00;
                    rsp_valid_q[gid_q] <= 1'b1;
                    state_q            <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[gid_q]) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign flags        = flags_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire
